// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding results in HI/LO, with Busy for the hazard unit.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10) accumulating into {HI,LO}.
module e_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDU_Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic is_mul, is_div, is_mthi, is_mtlo;

    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        case (MDU_Op)
            OP_MULT, OP_MULTU: is_mul  = 1'b1;
            OP_DIV, OP_DIVU:   is_div  = 1'b1;
            OP_MTHI:           is_mthi = 1'b1;
            OP_MTLO:           is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: is_mul  = 1'b1;
`endif
            default: ;
        endcase
    end

    logic [2*WIDTH-1:0] prod_s, prod_u, mul_res;
    logic               op_div_q, op_sgn_div;

    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign op_div_q   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign op_sgn_div = (op_q == OP_DIV);

    always_comb begin
        mul_res = prod_s;
        case (op_q)
            OP_MULTU: mul_res = prod_u;
`ifdef MDU_MADD_EN
            OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
            OP_MADDU: mul_res = {hi_q, lo_q} + prod_u;
            OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
            OP_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
`endif
            default:  mul_res = prod_s;
        endcase
    end

    // Signed division on magnitudes; MIN_INT/-1 falls out as LO=MIN_INT, HI=0.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, div_b, uq, ur, quo, rem;

    always_comb begin
        a_neg = op_sgn_div & a_q[WIDTH-1];
        b_neg = op_sgn_div & b_q[WIDTH-1];
        mag_a = a_neg ? (~a_q + 1'b1) : a_q;
        mag_b = b_neg ? (~b_q + 1'b1) : b_q;
        div_b = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quo   = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
        rem   = a_neg ? (~ur + 1'b1) : ur;
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                if (!op_div_q) begin
                    {hi_d, lo_d} = mul_res;
                end else if (b_q != '0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
        end else if (Start) begin
            if (is_mul || is_div) begin
                busy_d = 1'b1;
                cnt_d  = is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                op_d   = MDU_Op;
                a_d    = SrcA;
                b_d    = SrcB;
            end else if (is_mthi) begin
                hi_d = SrcA;
            end else if (is_mtlo) begin
                lo_d = SrcA;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: issued ops push expected HI/LO and busy length,
// a monitor checks them when Busy falls.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [3:0]  MDU_Op;
    logic [31:0] SrcA, SrcB;
    logic        Busy;
    logic [31:0] HI, LO;

    e_mdu dut (
        .clk(clk), .reset(rst_n), .Start(Start), .MDU_Op(MDU_Op),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on every busy->idle transition; reset flushes pending work.
    int   bcnt = 0;
    logic prev = 1'b0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            bcnt = 0;
            prev = 1'b0;
        end else begin
            if (Busy === 1'b1) begin
                bcnt++;
            end else if (prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_commit", 64'(q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_hi", 64'(HI), 64'(e.hi));
                    chk("sb_lo", 64'(LO), 64'(e.lo));
                    chk("sb_busy_cycles", 64'(bcnt), 64'(e.n));
                end
                bcnt = 0;
            end
            prev = (Busy === 1'b1);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        MDU_Op = op;
        SrcA   = a;
        SrcB   = b;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        MDU_Op = 4'd0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (Busy !== 1'b0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_timeout", 64'(Busy), 64'd0);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int n);
        q.push_back('{hi: ehi, lo: elo, n: n});
        issue(op, a, b);
        wait_idle();
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        rst_n  = 1'b0;
        Start  = 1'b0;
        MDU_Op = 4'd0;
        SrcA   = 32'd0;
        SrcB   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);

        run(4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        run(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        run(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run(4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
        run(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        run(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

        issue(4'd5, 32'h1234, 32'd0);
        chk("mthi_hi", 64'(HI), 64'h1234);
        chk("mthi_busy", 64'(Busy), 64'd0);
        m_hi = 32'h1234;
        run(4'd3, 32'd9, 32'd0, m_hi, m_lo, 10);
        run(4'd4, 32'd5, 32'd0, m_hi, m_lo, 10);

        issue(4'd0, 32'h55, 32'h66);
        chk("op0_busy", 64'(Busy), 64'd0);
        issue(4'd15, 32'h55, 32'h66);
        chk("op15_busy", 64'(Busy), 64'd0);
        chk("undef_hilo", {HI, LO}, {m_hi, m_lo});

        q.push_back('{hi: 32'd0, lo: 32'd6, n: 5});
        issue(4'd1, 32'd2, 32'd3);
        @(posedge clk);
        #1;
        issue(4'd6, 32'hAA, 32'd0);
        wait_idle();
        chk("ignored_mtlo_lo", 64'(LO), 64'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;

        issue(4'd3, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_hilo", {HI, LO}, 64'd0);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("postrst_busy", 64'(Busy), 64'd0);
        chk("postrst_hilo", {HI, LO}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        issue(4'd6, 32'd10, 32'd0);
        chk("mtlo_lo", 64'(LO), 64'd10);
        m_lo = 32'd10;
`ifdef MDU_MADD_EN
        run(4'd7, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd4, 5);
        run(4'd9, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
`else
        issue(4'd7, 32'hFFFFFFFE, 32'd3);
        chk("op7_busy", 64'(Busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("op7_busy_late", 64'(Busy), 64'd0);
        chk("op7_hilo", {HI, LO}, {32'd0, 32'd10});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
